ieeedrv_sd_mux: RTL and testbench
=================================

Name: ieeedrv_sd_mux

Overview:
- Downstream arbiter between the per-subdrive SD request ports of the drive top level and a single host SD block channel.
- Grants one subdrive at a time, round-robin, to the shared channel.
- Routes ack, buffer write strobes and write-back data for the granted subdrive.
- Lets a dual drive (8250/4040) share one image slot interface when the host exposes fewer SD channels than subdrives.

Parameters:
SUBDRV, 2, number of subdrives arbitrated (1..4)
TIMEOUT, 24'd8000000, clk_sys cycles to wait for host ack (only used with IEEEDRV_SD_TIMEOUT_EN)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
req_lba[SUBDRV]  in  32  per-subdrive block address
req_blk_cnt[SUBDRV]  in  6  per-subdrive block count minus one
req_rd  in  SUBDRV  per-subdrive read request, level, held until its ack rises
req_wr  in  SUBDRV  per-subdrive write request, level, held until its ack rises
req_ack  out  SUBDRV  per-subdrive ack
req_buff_wr  out  SUBDRV  per-subdrive buffer write strobe
req_buff_din[SUBDRV]  in  8  per-subdrive write-back data
sd_lba  out  32  host block address
sd_blk_cnt  out  6  host block count
sd_rd  out  1  host read request
sd_wr  out  1  host write request
sd_ack  in  1  host ack
sd_buff_wr  in  1  host buffer write strobe
sd_buff_din  out  8  host write-back data
grant  out  SUBDRV  one-hot owner of the channel, 0 when idle
err  out  SUBDRV  one-cycle timeout pulse per subdrive

Behaviour:
- Clock and reset: single clock clk_sys; reset is synchronous, active-high.
- States: IDLE, ISSUE, XFER, DONE.
- Reset: state=IDLE, grant=0, sd_rd=sd_wr=0, sd_lba=0, sd_blk_cnt=0, err=0, rr pointer=0, wait_ack_low=1.
- IDLE:
  - Stays in IDLE while wait_ack_low=1 and sd_ack=1 (host transfer left over from before reset). Clears wait_ack_low once sd_ack=0.
  - Otherwise scans for pending subdrives (req_rd|req_wr) starting at the rr pointer, wrapping modulo SUBDRV.
  - First hit g is granted and registered: grant[g]=1; sd_lba/sd_blk_cnt latched from req_lba[g]/req_blk_cnt[g]; sd_wr=req_wr[g]; sd_rd=req_rd[g]&~req_wr[g] (write wins if both are set). Next state ISSUE.
  - Latency: request visible in cycle N -> sd_rd/sd_wr high in cycle N+1.
- ISSUE: holds sd_rd/sd_wr and the latched address. On sd_ack=1, clears sd_rd/sd_wr next cycle and moves to XFER. Request withdrawal by the subdrive is ignored; the host cannot abort.
- XFER: holds while sd_ack=1. On sd_ack=0, goes to DONE.
- DONE: one cycle; grant cleared; rr pointer=(g+1) mod SUBDRV; then IDLE. This gives one idle cycle between grants, so a back-to-back request re-arbitrates fairly.
- Routing (combinational):
  - req_ack[i]=sd_ack & grant[i].
  - req_buff_wr[i]=sd_buff_wr & sd_ack & grant[i].
  - sd_buff_din=req_buff_din[g] when granted, else 8'h00.
  - Non-granted subdrives see ack=0 and buff_wr=0 at all times.
- sd_lba and sd_blk_cnt are stable from grant until DONE. They hold their last value in IDLE.
- Reset while in ISSUE/XFER: outputs cleared in the same edge, and wait_ack_low=1 blocks new grants until the host drops ack. Late host strobes are not forwarded because grant=0.
- SUBDRV=1: the pointer is constant 0; behaviour is otherwise unchanged.

Optional Feature:
IEEEDRV_SD_TIMEOUT_EN
- Defined:
  - A 24-bit counter loads TIMEOUT on entry to ISSUE and decrements each cycle.
  - Reaching 0 with sd_ack still 0: sd_rd/sd_wr cleared, err[g] pulses 1 cycle, DONE path taken (rr advances), wait_ack_low=1.
  - The counter is not active in XFER.
- Undefined: ISSUE waits indefinitely; err tied to 0; no counter logic.

Test Plan:
- Single read: req_rd=2'b01, req_lba[0]=357 -> sd_rd=1 with sd_lba=357 one cycle later. Host ack for 256 strobes -> req_buff_wr[0] pulses 256 times, req_buff_wr[1]=0, grant returns 0 after ack falls +1 cycle.
- Simultaneous requests: req_rd=2'b11, rr=0 -> subdrive 0 served first, then subdrive 1. With both re-requesting continuously, grants alternate 0,1,0,1.
- Write path: req_wr[1]=1, req_buff_din[1]=8'hA5 -> sd_wr=1, sd_rd=0, sd_buff_din=8'hA5 while grant=2'b10. req_rd[1] and req_wr[1] both set -> sd_wr only.
- Reset mid-XFER with sd_ack held high 10 more cycles and req_rd[0]=1 -> no grant, no req_ack, until sd_ack falls; grant appears 1 cycle later.
- Timeout (macro defined, TIMEOUT=16): req_rd[1]=1, host never acks -> sd_rd drops at cycle 17 after issue, err[1] pulses 1 cycle, next pending subdrive 0 is granted.
- Withdrawal: req_rd[0] dropped during ISSUE -> sd_rd stays 1 until sd_ack, transfer completes, DONE reached normally.

Source files
------------

// File: rtl/ieeedrv_sd_mux.sv
// ieeedrv_sd_mux
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares one host SD block channel between up to four
// drive subdrives. One subdrive owns the channel at a time. The owner's
// address, count and rd/wr request are latched onto the host side. The host's
// ack, buffer write strobe and the owner's write-back data are routed back.
//
// Build option: define IEEEDRV_SD_TIMEOUT_EN to abort an ISSUE that the host
// never acks within TIMEOUT clk_sys cycles. The aborted subdrive gets a
// one-cycle err pulse.
//
// Ports
//   clk_sys, reset          system clock, synchronous active-high reset
//   req_lba/req_blk_cnt     per-subdrive block address / count-1 (flattened,
//                           subdrive i occupies slice [i*W +: W])
//   req_rd, req_wr          per-subdrive level requests, held until ack rises
//   req_ack, req_buff_wr    per-subdrive ack / buffer write strobe (owner only)
//   req_buff_din            per-subdrive write-back data (flattened, 8 bits)
//   sd_lba, sd_blk_cnt      host block address / count, stable while granted
//   sd_rd, sd_wr            host request, dropped once the host acks
//   sd_ack, sd_buff_wr      host ack / buffer write strobe
//   sd_buff_din             owner's write-back data, 8'h00 when idle
//   grant                   one-hot channel owner, 0 when idle
//   err                     one-cycle timeout pulse per subdrive
// ----------------------------------------------------------------------------
module ieeedrv_sd_mux #(
  parameter int          SUBDRV  = 2,
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [SUBDRV*32-1:0] req_lba,
  input  logic [SUBDRV*6-1:0]  req_blk_cnt,
  input  logic [SUBDRV-1:0]    req_rd,
  input  logic [SUBDRV-1:0]    req_wr,
  output logic [SUBDRV-1:0]    req_ack,
  output logic [SUBDRV-1:0]    req_buff_wr,
  input  logic [SUBDRV*8-1:0]  req_buff_din,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din,
  output logic [SUBDRV-1:0]    grant,
  output logic [SUBDRV-1:0]    err
);

  localparam int IDX_W = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

  // Elaboration-time sanity check of the configuration.
  if (SUBDRV < 1 || SUBDRV > 4 || TIMEOUT == 24'd0) begin : g_bad_cfg
    $error("ieeedrv_sd_mux: SUBDRV must be 1..4 and TIMEOUT non-zero");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SUBDRV-1:0]   grant_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    rr_q;
  logic                wait_ack_low_q;

  // Per-subdrive views of the flattened buses.
  logic [31:0] lba_a [SUBDRV];
  logic [5:0]  blk_a [SUBDRV];
  logic [7:0]  din_a [SUBDRV];

  for (genvar i = 0; i < SUBDRV; i++) begin : g_unpack
    assign lba_a[i] = req_lba[i*32 +: 32];
    assign blk_a[i] = req_blk_cnt[i*6 +: 6];
    assign din_a[i] = req_buff_din[i*8 +: 8];
  end

  // --------------------------------------------------------------------------
  // Round-robin scan: first pending subdrive at or after rr_q, wrapping.
  // --------------------------------------------------------------------------
  logic [SUBDRV-1:0] pending;
  logic              scan_hit;
  logic [IDX_W-1:0]  scan_idx;

  assign pending = req_rd | req_wr;

  always_comb begin : p_scan
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable driven here gets a default before any branch,
    // otherwise paths that skip an assignment would infer latches.
    scan_hit = 1'b0;
    scan_idx = '0;
    sum      = '0;
    cand     = '0;
    for (int off = 0; off < SUBDRV; off++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(SUBDRV)) sum = sum - (IDX_W+1)'(SUBDRV);
      cand = sum[IDX_W-1:0];
      if (!scan_hit && pending[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // A host transfer still running from before reset blocks arbitration
  // until the host drops ack.
  logic arb_block;
  logic grant_fire;

  assign arb_block  = wait_ack_low_q & sd_ack;
  assign grant_fire = (state_q == IDLE) && !arb_block && scan_hit;

  // --------------------------------------------------------------------------
  // Optional host-ack timeout
  // --------------------------------------------------------------------------
  logic tmo_fire;

`ifdef IEEEDRV_SD_TIMEOUT_EN
  logic [23:0]       tmo_q;
  logic [SUBDRV-1:0] err_q;

  assign tmo_fire = (state_q == ISSUE) && !sd_ack && (tmo_q == 24'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_q <= 24'd0;
    end else if (grant_fire) begin
      tmo_q <= TIMEOUT;
    end else if (state_q == ISSUE && tmo_q != 24'd0) begin
      tmo_q <= tmo_q - 24'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (tmo_fire) err_q[owner_q] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err      = '0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before this clock edge.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = ISSUE;
      ISSUE: begin
        if (sd_ack)        state_d = XFER;
        else if (tmo_fire) state_d = DONE;
      end
      XFER:    if (!sd_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered channel datapath
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_next;

  // Pointer to the subdrive after the current owner, modulo SUBDRV.
  assign rr_next = (owner_q == IDX_W'(SUBDRV - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant_q        <= '0;
      owner_q        <= '0;
      rr_q           <= '0;
      sd_rd          <= 1'b0;
      sd_wr          <= 1'b0;
      sd_lba         <= 32'd0;
      sd_blk_cnt     <= 6'd0;
      wait_ack_low_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!sd_ack) wait_ack_low_q <= 1'b0;
          if (grant_fire) begin
            grant_q    <= SUBDRV'(1) << scan_idx;
            owner_q    <= scan_idx;
            sd_lba     <= lba_a[scan_idx];
            sd_blk_cnt <= blk_a[scan_idx];
            // Write wins when a subdrive raises both requests.
            sd_wr      <= req_wr[scan_idx];
            sd_rd      <= req_rd[scan_idx] & ~req_wr[scan_idx];
          end
        end
        ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else if (tmo_fire) begin
            // Abandon the request; the host may still ack late, so hold off
            // the next grant until ack is seen low.
            sd_rd          <= 1'b0;
            sd_wr          <= 1'b0;
            grant_q        <= '0;
            rr_q           <= rr_next;
            wait_ack_low_q <= 1'b1;
          end
        end
        XFER: begin
          if (!sd_ack) begin
            grant_q <= '0;
            rr_q    <= rr_next;
          end
        end
        DONE: begin
          // Single idle cycle so a subdrive re-requesting at once still has
          // to compete with the others through the advanced pointer.
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM outputs: routing between host and the granted subdrive
  // --------------------------------------------------------------------------
  always_comb begin
    req_ack     = grant_q & {SUBDRV{sd_ack}};
    req_buff_wr = grant_q & {SUBDRV{sd_ack & sd_buff_wr}};
    sd_buff_din = (|grant_q) ? din_a[owner_q] : 8'h00;
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_ieeedrv_sd_mux.sv
// tb_ieeedrv_sd_mux
// ----------------------------------------------------------------------------
// Directed scenarios followed by a randomized run for ieeedrv_sd_mux with two
// subdrives. The bench plays both the subdrives (request arrays m_*) and the
// host (sd_ack / sd_buff_wr). Expected owners come from the round-robin rule
// applied to the bench's own record of pending requests.
// ----------------------------------------------------------------------------
module tb_ieeedrv_sd_mux;

  localparam int NSUB = 2;

  logic                clk_sys = 1'b0;
  logic                reset;
  logic [NSUB*32-1:0]  req_lba;
  logic [NSUB*6-1:0]   req_blk_cnt;
  logic [NSUB-1:0]     req_rd;
  logic [NSUB-1:0]     req_wr;
  logic [NSUB-1:0]     req_ack;
  logic [NSUB-1:0]     req_buff_wr;
  logic [NSUB*8-1:0]   req_buff_din;
  logic [31:0]         sd_lba;
  logic [5:0]          sd_blk_cnt;
  logic                sd_rd;
  logic                sd_wr;
  logic                sd_ack;
  logic                sd_buff_wr;
  logic [7:0]          sd_buff_din;
  logic [NSUB-1:0]     grant;
  logic [NSUB-1:0]     err;

  ieeedrv_sd_mux #(
    .SUBDRV  (NSUB),
    .TIMEOUT (24'd16)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_lba      (req_lba),
    .req_blk_cnt  (req_blk_cnt),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_wr  (req_buff_wr),
    .req_buff_din (req_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .grant        (grant),
    .err          (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Subdrive-side request records.
  bit          m_rd  [NSUB];
  bit          m_wr  [NSUB];
  logic [31:0] m_lba [NSUB];
  logic [5:0]  m_blk [NSUB];
  logic [7:0]  m_din [NSUB];

  int n_cmp = 0;
  int n_bad = 0;

  // Buffer-write strobes seen per subdrive, sampled mid-cycle.
  int bw_cnt [NSUB] = '{default: 0};
  always @(negedge clk_sys) begin
    for (int i = 0; i < NSUB; i++) if (req_buff_wr[i]) bw_cnt[i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [NSUB-1:0] oh(input int i);
    return NSUB'(1) << i;
  endfunction

  task automatic apply();
    for (int i = 0; i < NSUB; i++) begin
      req_lba[i*32 +: 32]     = m_lba[i];
      req_blk_cnt[i*6 +: 6]   = m_blk[i];
      req_buff_din[i*8 +: 8]  = m_din[i];
      req_rd[i]               = m_rd[i];
      req_wr[i]               = m_wr[i];
    end
  endtask

  // Round-robin rule: first pending subdrive at or after the pointer.
  function automatic int pick(input int rr);
    for (int off = 0; off < NSUB; off++) begin
      int k;
      k = (rr + off) % NSUB;
      if (m_rd[k] || m_wr[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NSUB; i++) if (m_rd[i] || m_wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic new_req(input int s);
    int kind;
    kind     = $urandom_range(0, 2);
    m_lba[s] = $urandom();
    m_blk[s] = 6'($urandom_range(0, 63));
    m_din[s] = 8'($urandom_range(0, 255));
    m_rd[s]  = (kind != 1);
    m_wr[s]  = (kind != 0);
  endtask

  // Advance until the host sees a request; bounded.
  task automatic wait_req(input int limit, output int cyc);
    cyc = 0;
    while (!(sd_rd || sd_wr) && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  // Host acks, issues n strobe slots, then drops ack.
  task automatic serve(input int owner, input int n, input bit dense,
                       input bit drop, output int sent);
    sent   = 0;
    sd_ack = 1'b1;
    #1;
    check("ack_routed", req_ack, oh(owner));
    for (int i = 0; i < n; i++) begin
      sd_buff_wr = dense ? 1'b1 : 1'($urandom_range(0, 1));
      if (sd_buff_wr) sent++;
      step();
      if (i == 0) begin
        check("rdwr_cleared_on_ack", {sd_rd, sd_wr}, 2'b00);
        if (drop) begin
          m_rd[owner] = 1'b0;
          m_wr[owner] = 1'b0;
          apply();
        end
      end
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
  endtask

  // Ack just dropped: grant clears the next cycle, then one idle cycle.
  task automatic finish_xfer(input string tag);
    step();
    check({tag, "_grant_cleared"}, grant, '0);
    check({tag, "_din_idle"}, sd_buff_din, 8'h00);
    step();
    check({tag, "_idle_no_ack"}, req_ack, '0);
  endtask

  task automatic check_strobes(input string tag, input int owner, input int sent,
                               input int snap [NSUB]);
    for (int i = 0; i < NSUB; i++)
      check({tag, "_strobes"}, bw_cnt[i] - snap[i], (i == owner) ? sent : 0);
  endtask

  initial begin
    int cyc, sent, exp, hi, d, m_rr;
    int snap [NSUB];

    reset = 1'b1; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    for (int i = 0; i < NSUB; i++) begin
      m_rd[i] = 0; m_wr[i] = 0; m_lba[i] = '0; m_blk[i] = '0; m_din[i] = '0;
    end
    apply();
    step(); step();

    // Reset state
    check("rst_grant", grant, '0);
    check("rst_rdwr", {sd_rd, sd_wr}, 2'b00);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_blk", sd_blk_cnt, 6'd0);
    check("rst_err", err, '0);
    check("rst_ack", req_ack, '0);
    check("rst_bw", req_buff_wr, '0);
    check("rst_din", sd_buff_din, 8'h00);
    reset = 1'b0;

    // Single read, 256 strobes
    m_rd[0] = 1; m_lba[0] = 32'd357; m_blk[0] = 6'd3; apply();
    wait_req(6, cyc);
    check("t1_latency", cyc, 1);
    check("t1_grant", grant, 2'b01);
    check("t1_rdwr", {sd_rd, sd_wr}, 2'b10);
    check("t1_lba", sd_lba, 32'd357);
    check("t1_blk", sd_blk_cnt, 6'd3);
    snap = bw_cnt;
    serve(0, 256, 1'b1, 1'b1, sent);
    finish_xfer("t1");
    check_strobes("t1", 0, 256, snap);
    check("t1_lba_hold", sd_lba, 32'd357);

    // Simultaneous requests from rr=0, alternating grants
    reset = 1'b1; step(); reset = 1'b0;
    m_rd[0] = 1; m_rd[1] = 1; m_lba[1] = 32'h1234; apply();
    wait_req(6, cyc);
    check("t2_latency", cyc, 1);
    for (int k = 0; k < 4; k++) begin
      check("t2_grant", grant, oh(k % 2));
      check("t2_lba", sd_lba, (k % 2) ? 32'h1234 : 32'd357);
      serve(k % 2, 4, 1'b1, 1'b0, sent);
      if (k == 3) begin
        m_rd[0] = 0; m_rd[1] = 0; apply();
      end
      finish_xfer("t2");
      if (k < 3) begin
        wait_req(6, cyc);
        check("t2_regrant_latency", cyc, 1);
      end
    end

    // Write path, then write-wins when both are set
    m_wr[1] = 1; m_din[1] = 8'hA5; m_lba[1] = $urandom(); apply();
    wait_req(6, cyc);
    check("t3_grant", grant, 2'b10);
    check("t3_rdwr", {sd_rd, sd_wr}, 2'b01);
    check("t3_din", sd_buff_din, 8'hA5);
    check("t3_lba", sd_lba, m_lba[1]);
    snap = bw_cnt;
    serve(1, 6, 1'b0, 1'b1, sent);
    finish_xfer("t3");
    check_strobes("t3", 1, sent, snap);
    m_rd[1] = 1; m_wr[1] = 1; apply();
    wait_req(6, cyc);
    check("t3_both_rdwr", {sd_rd, sd_wr}, 2'b01);
    check("t3_err", err, '0);
    serve(1, 2, 1'b1, 1'b1, sent);
    finish_xfer("t3b");

    // Reset mid-XFER with the host still acking
    m_rd[0] = 1; m_lba[0] = 32'd100; apply();
    wait_req(6, cyc);
    check("t4_grant", grant, 2'b01);
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    check("t4_rst_grant", grant, '0);
    check("t4_rst_rd", sd_rd, 1'b0);
    check("t4_rst_lba", sd_lba, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("t4_blocked_grant", grant, '0);
      check("t4_blocked_ack", req_ack, '0);
      check("t4_blocked_bw", req_buff_wr, '0);
      step();
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    wait_req(6, cyc);
    check("t4_release_latency", cyc, 1);
    check("t4_release_grant", grant, 2'b01);
    check("t4_release_lba", sd_lba, 32'd100);
    serve(0, 3, 1'b1, 1'b1, sent);
    finish_xfer("t4");

`ifdef IEEEDRV_SD_TIMEOUT_EN
    // Host never acks subdrive 1; subdrive 0 waits behind it
    m_rd[1] = 1; apply();
    wait_req(6, cyc);
    check("t5_grant", grant, 2'b10);
    m_rd[0] = 1; apply();
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!sd_rd) break;
      hi++;
    end
    check("t5_rd_high_cycles", hi, 17);
    check("t5_err_pulse", err, 2'b10);
    check("t5_grant_cleared", grant, '0);
    step();
    check("t5_err_one_cycle", err, '0);
    wait_req(6, cyc);
    check("t5_next_latency", cyc, 1);
    check("t5_next_grant", grant, 2'b01);
    serve(0, 2, 1'b1, 1'b1, sent);
    finish_xfer("t5a");
    wait_req(6, cyc);
    check("t5_retry_grant", grant, 2'b10);
    serve(1, 2, 1'b1, 1'b1, sent);
    finish_xfer("t5b");
`else
    // Without the timeout ISSUE waits for the host indefinitely
    m_rd[0] = 1; apply();
    wait_req(6, cyc);
    repeat (40) step();
    check("t5_still_rd", sd_rd, 1'b1);
    check("t5_still_grant", grant, 2'b01);
    check("t5_no_err", err, '0);
    serve(0, 2, 1'b1, 1'b1, sent);
    finish_xfer("t5");
`endif

    // Withdrawal during ISSUE is ignored
    m_rd[0] = 1; m_lba[0] = 32'hCAFE_0001; apply();
    wait_req(6, cyc);
    check("t6_grant", grant, 2'b01);
    m_rd[0] = 0; apply();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_rd_held", sd_rd, 1'b1);
      check("t6_lba_held", sd_lba, 32'hCAFE_0001);
    end
    snap = bw_cnt;
    serve(0, 8, 1'b1, 1'b0, sent);
    finish_xfer("t6");
    check_strobes("t6", 0, 8, snap);

    // Randomized traffic against the round-robin rule
    reset = 1'b1; step(); reset = 1'b0;
    m_rr = 0;
    for (int t = 0; t < 40; t++) begin
      if (!any_pending()) begin
        new_req($urandom_range(0, NSUB - 1));
        apply();
      end
      wait_req(6, cyc);
      check("rnd_latency", cyc, 1);
      exp = pick(m_rr);
      check("rnd_grant", grant, oh(exp));
      check("rnd_lba", sd_lba, m_lba[exp]);
      check("rnd_blk", sd_blk_cnt, m_blk[exp]);
      check("rnd_rdwr", {sd_rd, sd_wr}, {m_rd[exp] & ~m_wr[exp], m_wr[exp]});
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        step();
        check("rnd_issue_hold", {sd_rd | sd_wr, sd_lba}, {1'b1, m_lba[exp]});
      end
      check("rnd_din", sd_buff_din, m_din[exp]);
      snap = bw_cnt;
      serve(exp, $urandom_range(1, 20), 1'b0, 1'b1, sent);
      for (int s = 0; s < NSUB; s++)
        if (!(m_rd[s] || m_wr[s]) && $urandom_range(0, 1) == 1) new_req(s);
      apply();
      finish_xfer("rnd");
      check_strobes("rnd", exp, sent, snap);
      m_rr = (exp + 1) % NSUB;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
